memoria_instrucciones_sync: RTL
===============================

// Module: memoria_instrucciones_sync
// PURPOSE
//  Parametrised, synchronous-read instruction memory feeding the IF stage of the MIPS pipeline.
//  Byte-addressed PC in; word-aligned registered fetch out; debug-unit write/readback port;
//  stall/flush control and HALT-word detection (32'hFFFF_FFFF) for the debug unit.
// PARAMETERS
//  NBITS     32   instruction/data word width
//  CELDAS    256  depth in words (power of two); byte address span = 4*CELDAS
//  HALT_WORD {NBITS{1'b1}}  word that raises o_halt when fetched
// PORTS
//  i_clk            in   1      clock; all state changes on rising edge
//  i_reset          in   1      asynchronous, active-low reset
//  i_PC             in   NBITS  fetch byte address
//  i_enable         in   1      1 = fetch this cycle; 0 = stall, outputs hold
//  i_flush          in   1      replace next output with NOP
//  i_DirecDebug     in   NBITS  debug byte address (write and readback)
//  i_DatoDebug      in   NBITS  debug write data
//  i_WriteDebug     in   1      debug write strobe, level-sampled on i_clk
//  o_Instruction    out  NBITS  registered fetched instruction
//  o_valid          out  1      o_Instruction holds a real fetch (not reset/flush/fault NOP)
//  o_halt           out  1      o_Instruction == HALT_WORD and o_valid
//  o_fault          out  1      last fetch misaligned (i_PC[1:0]!=0) or out of range
//  o_DatoDebug      out  NBITS  registered readback of word at i_DirecDebug
// BEHAVIOUR
//  - Reset (i_reset=0, async): o_Instruction=0, o_valid=0, o_halt=0, o_fault=0, o_DatoDebug=0.
//    Array contents NOT reset. Deassertion is synchronised externally; first fetch on first edge after.
//  - Word index = addr[$clog2(CELDAS)+1:2]; range fault when addr >= 4*CELDAS.
//  - Fetch latency 1 cycle: i_PC at edge N -> o_Instruction valid after edge N.
//  - Priority per edge: flush > stall > fault > normal fetch.
//    flush: o_Instruction=0 (NOP), o_valid=0, o_fault=0, o_halt=0 (even when i_enable=0).
//    stall (i_enable=0, no flush): all fetch outputs hold.
//    fault: o_Instruction=0, o_valid=0, o_fault=1; array untouched.
//  - Debug write: when i_WriteDebug=1 at edge, mem[idx(i_DirecDebug)] <= i_DatoDebug;
//    misaligned/out-of-range debug writes are dropped silently. Multi-cycle strobe = repeated same write.
//  - Read-during-write same word same edge: fetch returns NEW data (write-first bypass); same for readback.
//  - o_DatoDebug updates every edge (1-cycle latency), independent of i_enable/i_flush; 0 if out of range.
//  - Reset asserted mid-write: write in that cycle is discarded; array otherwise preserved.
// CONFIGURATION
//  INSTR_MEM_PARITY_EN defined: array stores NBITS+1 bits (even parity generated on debug write);
//   fetch checks parity; mismatch -> o_Instruction=0, o_valid=0, o_fault=1 (same as fault path).
//  Not defined: array NBITS wide, no check; parity logic absent.
// STRUCTURE
//  Package memoria_pkg: NOP_WORD, HALT_WORD default, addr->index function, parity function.
//  Sub-module ram_1r1w_sync (array + write-first bypass, one fetch read, one debug read, one write);
//  top holds control, fault/parity decode and output registers.
// TESTING
//  1. Reset, debug-write 0x00221820 to addr 4, PC=4 enable=1 -> next cycle Instruction=0x00221820, valid=1.
//  2. PC=6 -> Instruction=0, valid=0, fault=1; PC=4*CELDAS -> fault=1.
//  3. PC=4 fetch then enable=0 two cycles with PC=8 -> outputs hold 0x00221820; flush=1 -> Instruction=0, valid=0.
//  4. Write 0xFFFFFFFF to addr 8 while fetching PC=8 same edge -> Instruction=0xFFFFFFFF, halt=1.
//  5. Assert i_reset=0 mid-cycle during write to addr 12 -> outputs 0 immediately, addr 12 unchanged on readback.
//  6. PARITY_EN: force-flip one array bit at addr 4, fetch PC=4 -> fault=1, valid=0, Instruction=0.

Source files
------------

// File: rtl/memoria_pkg.sv
// Shared constants and address/parity helpers for the IF-stage instruction memory.
// Optional INSTR_MEM_PARITY_EN support relies on even_parity() defined here.
package memoria_pkg;

    localparam int unsigned NBITS_DEF  = 32;
    localparam int unsigned CELDAS_DEF = 256;

    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    // Byte address -> word index; callers size-cast the result to their index width.
    function automatic logic [63:0] word_index(input logic [63:0] addr, input int unsigned aw);
        return (addr >> 2) & ((64'd1 << aw) - 64'd1);
    endfunction

    function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned celdas);
        return addr < (64'(celdas) << 2);
    endfunction

    function automatic logic addr_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

    // XOR reduction; zero extension does not change the result.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ram_1r1w_sync.sv
// Word array with one write port and two registered read ports (fetch, debug).
// Both reads are write-first: a same-edge write to the read word returns the new data.
module ram_1r1w_sync #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          f_en,
    input  logic [AW-1:0] f_addr,
    output logic [W-1:0]  f_q,
    input  logic [AW-1:0] d_addr,
    output logic [W-1:0]  d_q
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Fetch port only advances when enabled, so a stall holds the last word.
    always_ff @(posedge clk) begin
        if (f_en) begin
            f_q <= (we && (waddr == f_addr)) ? wdata : mem[f_addr];
        end
    end

    always_ff @(posedge clk) begin
        d_q <= (we && (waddr == d_addr)) ? wdata : mem[d_addr];
    end

endmodule

// File: rtl/memoria_instrucciones_sync.sv
// Synchronous-read instruction memory for the MIPS IF stage, with debug write/readback.
// Define INSTR_MEM_PARITY_EN to store an even-parity bit per word and check it on fetch.
module memoria_instrucciones_sync
    import memoria_pkg::*;
#(
    parameter int unsigned       NBITS     = NBITS_DEF,
    parameter int unsigned       CELDAS    = CELDAS_DEF,
    parameter logic [NBITS-1:0]  HALT_WORD = {NBITS{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NBITS-1:0] i_PC,
    input  logic             i_enable,
    input  logic             i_flush,
    input  logic [NBITS-1:0] i_DirecDebug,
    input  logic [NBITS-1:0] i_DatoDebug,
    input  logic             i_WriteDebug,
    output logic [NBITS-1:0] o_Instruction,
    output logic             o_valid,
    output logic             o_halt,
    output logic             o_fault,
    output logic [NBITS-1:0] o_DatoDebug
);

    localparam int unsigned AW = $clog2(CELDAS);
`ifdef INSTR_MEM_PARITY_EN
    localparam int unsigned MW = NBITS + 1;
`else
    localparam int unsigned MW = NBITS;
`endif

    // Handshake: i_enable is the downstream ready; o_valid marks a real fetched word.
    // With i_enable=0 every fetch output holds; i_flush overrides and emits a NOP.

    logic [63:0]    pc_ext;
    logic [63:0]    dbg_ext;
    logic           pc_fault;
    logic           dbg_wr_ok;
    logic           dbg_rd_ok;
    logic [AW-1:0]  pc_idx;
    logic [AW-1:0]  dbg_idx;
    logic           ram_we;
    logic           fetch_en;
    logic [MW-1:0]  ram_wdata;
    logic [MW-1:0]  fetch_q;
    logic [MW-1:0]  dbg_q;

    logic           fetch_ok_q;
    logic           fault_q;
    logic           dbg_ok_q;

    logic           parity_err;
    logic [NBITS-1:0] fetch_word;
    logic [NBITS-1:0] dbg_word;

    assign pc_ext  = 64'(i_PC);
    assign dbg_ext = 64'(i_DirecDebug);

    assign pc_fault  = !addr_aligned(i_PC[1:0]) || !addr_in_range(pc_ext, CELDAS);
    assign dbg_wr_ok = addr_aligned(i_DirecDebug[1:0]) && addr_in_range(dbg_ext, CELDAS);
    assign dbg_rd_ok = addr_in_range(dbg_ext, CELDAS);

    assign pc_idx  = AW'(word_index(pc_ext, AW));
    assign dbg_idx = AW'(word_index(dbg_ext, AW));

    // Gating with i_reset drops a write that coincides with an edge during reset.
    assign ram_we   = i_WriteDebug && dbg_wr_ok && i_reset;
    assign fetch_en = i_enable && !i_flush && !pc_fault;

`ifdef INSTR_MEM_PARITY_EN
    assign ram_wdata = {even_parity(64'(i_DatoDebug)), i_DatoDebug};
`else
    assign ram_wdata = i_DatoDebug;
`endif

    ram_1r1w_sync #(
        .W     (MW),
        .DEPTH (CELDAS),
        .AW    (AW)
    ) u_ram (
        .clk    (i_clk),
        .we     (ram_we),
        .waddr  (dbg_idx),
        .wdata  (ram_wdata),
        .f_en   (fetch_en),
        .f_addr (pc_idx),
        .f_q    (fetch_q),
        .d_addr (dbg_idx),
        .d_q    (dbg_q)
    );

    // Flag registers; the data path sits in the RAM read registers and is masked here.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            fetch_ok_q <= 1'b0;
            fault_q    <= 1'b0;
            dbg_ok_q   <= 1'b0;
        end else begin
            dbg_ok_q <= dbg_rd_ok;
            if (i_flush) begin
                fetch_ok_q <= 1'b0;
                fault_q    <= 1'b0;
            end else if (i_enable) begin
                if (pc_fault) begin
                    fetch_ok_q <= 1'b0;
                    fault_q    <= 1'b1;
                end else begin
                    fetch_ok_q <= 1'b1;
                    fault_q    <= 1'b0;
                end
            end
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    // Stored word plus its parity bit must XOR to zero.
    assign parity_err = fetch_ok_q && even_parity(64'(fetch_q));
    assign fetch_word = fetch_q[NBITS-1:0];
    assign dbg_word   = dbg_q[NBITS-1:0];
`else
    assign parity_err = 1'b0;
    assign fetch_word = fetch_q;
    assign dbg_word   = dbg_q;
`endif

    assign o_valid       = fetch_ok_q && !parity_err;
    assign o_Instruction = o_valid ? fetch_word : NBITS'(NOP_WORD);
    assign o_fault       = fault_q || parity_err;
    assign o_halt        = o_valid && (fetch_word == HALT_WORD);
    assign o_DatoDebug   = dbg_ok_q ? dbg_word : '0;

endmodule
